// File: rtl/axi4_lite_write_master_q.sv
// Queued AXI4-lite write master with independent AW/W issue and in-order B retire.
// Define AXI_WR_STRB_EN to forward per-request byte strobes on W_STRB.
module axi4_lite_write_master_q #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int QDEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [ADDR_W-1:0]        REQ_ADDR,
    input  logic [DATA_W-1:0]        REQ_DATA,
    input  logic [DATA_W/8-1:0]      REQ_STRB,
    output logic [ADDR_W-1:0]        AW_ADDR,
    output logic [2:0]               AW_PROT,
    output logic                     AW_VALID,
    input  logic                     AW_READY,
    output logic [DATA_W-1:0]        W_DATA,
    output logic [DATA_W/8-1:0]      W_STRB,
    output logic                     W_VALID,
    input  logic                     W_READY,
    input  logic [1:0]               B_RESP,
    input  logic                     B_VALID,
    output logic                     B_READY,
    output logic                     DONE,
    output logic [1:0]               DONE_RESP,
    output logic [$clog2(QDEPTH):0]  PENDING
);
    localparam int IW = $clog2(QDEPTH);
    localparam int PW = IW + 1;
    localparam int SW = DATA_W / 8;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     aw_ptr;
    logic [PW-1:0]     w_ptr;
    logic [PW-1:0]     b_ptr;
    logic [ADDR_W-1:0] addr_q [QDEPTH];
    logic [DATA_W-1:0] data_q [QDEPTH];
    logic              enq;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;

    assign PENDING   = wr_ptr - b_ptr;
    assign REQ_READY = (PENDING != PW'(QDEPTH)) && RST;
    assign enq       = REQ_VALID && REQ_READY;

    assign AW_VALID  = (aw_ptr != wr_ptr);
    assign W_VALID   = (w_ptr != wr_ptr);
    // The oldest entry may retire only after both of its channels have gone out.
    assign B_READY   = (aw_ptr != b_ptr) && (w_ptr != b_ptr);

    assign aw_hs     = AW_VALID && AW_READY;
    assign w_hs      = W_VALID && W_READY;
    assign b_hs      = B_VALID && B_READY;

    assign AW_ADDR   = addr_q[aw_ptr[IW-1:0]];
    assign AW_PROT   = 3'b000;
    assign W_DATA    = data_q[w_ptr[IW-1:0]];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr    <= '0;
            aw_ptr    <= '0;
            w_ptr     <= '0;
            b_ptr     <= '0;
            DONE      <= 1'b0;
            DONE_RESP <= 2'b00;
        end else begin
            if (enq)   wr_ptr <= wr_ptr + PW'(1);
            if (aw_hs) aw_ptr <= aw_ptr + PW'(1);
            if (w_hs)  w_ptr  <= w_ptr + PW'(1);
            if (b_hs)  b_ptr  <= b_ptr + PW'(1);
            DONE <= b_hs;
            if (b_hs) DONE_RESP <= B_RESP;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            addr_q[wr_ptr[IW-1:0]] <= REQ_ADDR;
            data_q[wr_ptr[IW-1:0]] <= REQ_DATA;
        end
    end

`ifdef AXI_WR_STRB_EN
    logic [SW-1:0] strb_q [QDEPTH];

    always_ff @(posedge CLK) begin
        if (enq) strb_q[wr_ptr[IW-1:0]] <= REQ_STRB;
    end

    assign W_STRB = strb_q[w_ptr[IW-1:0]];
`else
    logic unused_strb;

    assign unused_strb = ^REQ_STRB;
    assign W_STRB      = {SW{1'b1}};
`endif

endmodule

// File: tb/tb_axi4_lite_write_master_q.sv
// Randomised bench for axi4_lite_write_master_q against a counter/queue model.
// The model tracks requests accepted, AW/W issued and writes retired.
module tb_axi4_lite_write_master_q;
    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [63:0] REQ_ADDR;
    logic [63:0] REQ_DATA;
    logic [7:0]  REQ_STRB;
    logic [63:0] AW_ADDR;
    logic [2:0]  AW_PROT;
    logic        AW_VALID;
    logic        AW_READY;
    logic [63:0] W_DATA;
    logic [7:0]  W_STRB;
    logic        W_VALID;
    logic        W_READY;
    logic [1:0]  B_RESP;
    logic        B_VALID;
    logic        B_READY;
    logic        DONE;
    logic [1:0]  DONE_RESP;
    logic [2:0]  PENDING;

    axi4_lite_write_master_q #(
        .ADDR_W(64), .DATA_W(64), .QDEPTH(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_STRB(REQ_STRB),
        .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB),
        .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
        .DONE(DONE), .DONE_RESP(DONE_RESP), .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  s;
    } req_t;

    req_t     reqs[$];
    int       tot_acc, tot_aw, tot_w, tot_ret;
    bit       exp_done;
    logic [1:0] exp_resp;
    int       n_cmp = 0;
    int       n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] exp_strb(input logic [7:0] s);
`ifdef AXI_WR_STRB_EN
        return s;
`else
        return (s | 8'hFF);
`endif
    endfunction

    // One clock: drive, check at negedge, advance the model after the edge.
    task automatic step(input bit rv, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s, input bit awr, input bit wr,
                        input bit bv, input logic [1:0] resp);
        int pend;
        bit e_rr, e_awv, e_wv, e_br;
        pend  = tot_acc - tot_ret;
        e_rr  = (pend != 4);
        e_awv = (tot_aw < tot_acc);
        e_wv  = (tot_w < tot_acc);
        e_br  = (tot_aw > tot_ret) && (tot_w > tot_ret);
        REQ_VALID = rv;
        REQ_ADDR  = a;
        REQ_DATA  = d;
        REQ_STRB  = s;
        AW_READY  = awr;
        W_READY   = wr;
        B_VALID   = bv && e_br;
        B_RESP    = resp;
        @(negedge CLK);
        chk("pending", 64'(PENDING), 64'(pend));
        chk("req_ready", 64'(REQ_READY), 64'(e_rr));
        chk("aw_valid", 64'(AW_VALID), 64'(e_awv));
        chk("w_valid", 64'(W_VALID), 64'(e_wv));
        chk("b_ready", 64'(B_READY), 64'(e_br));
        chk("aw_prot", 64'(AW_PROT), 64'(0));
        if (e_awv) chk("aw_addr", AW_ADDR, reqs[tot_aw].a);
        if (e_wv) begin
            chk("w_data", W_DATA, reqs[tot_w].d);
            chk("w_strb", 64'(W_STRB), 64'(exp_strb(reqs[tot_w].s)));
        end
        chk("done", 64'(DONE), 64'(exp_done));
        if (exp_done) chk("done_resp", 64'(DONE_RESP), 64'(exp_resp));
        @(posedge CLK);
        #1;
        if (rv && e_rr) begin
            reqs.push_back('{a, d, s});
            tot_acc++;
        end
        if (e_awv && awr) tot_aw++;
        if (e_wv && wr) tot_w++;
        exp_done = B_VALID;
        if (B_VALID) begin
            exp_resp = resp;
            tot_ret++;
        end
    endtask

    task automatic do_reset(input int n);
        RST       = 1'b0;
        REQ_VALID = 1'b0;
        B_VALID   = 1'b0;
        AW_READY  = 1'b0;
        W_READY   = 1'b0;
        repeat (n) begin
            @(negedge CLK);
            chk("rst_req_ready", 64'(REQ_READY), 64'(0));
            @(posedge CLK);
            #1;
        end
        RST      = 1'b1;
        tot_acc  = 0;
        tot_aw   = 0;
        tot_w    = 0;
        tot_ret  = 0;
        exp_done = 1'b0;
        exp_resp = 2'b00;
        reqs.delete();
    endtask

    task automatic rstep(input bit rv, input bit awr, input bit wr,
                         input bit bv, input logic [1:0] resp);
        step(rv, rnd64(), rnd64(), 8'($urandom()), awr, wr, bv, resp);
    endtask

    initial begin
        REQ_ADDR = '0;
        REQ_DATA = '0;
        REQ_STRB = '0;
        B_RESP   = 2'b00;
        do_reset(2);

        // Single write, full strobes
        step(1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1, 1, 0, 0);
        repeat (4) rstep(0, 1, 1, 1, 2'b00);

        // Single write with partial strobes
        step(1, 64'h8000_0020, 64'hDEAD_BEEF_0BAD_F00D, 8'h0F, 1, 1, 0, 0);
        repeat (4) rstep(0, 1, 1, 1, 2'b00);

        // Fill queue with both channels stalled, then drain
        repeat (6) rstep(1, 0, 0, 0, 2'b00);
        repeat (10) rstep(1, 1, 1, 1, 2'b00);
        repeat (4) rstep(0, 1, 1, 1, 2'b00);

        // Decoupled channels: W runs ahead of AW
        for (int i = 0; i < 10; i++) rstep(i < 3, 0, 1, 1, 2'b00);
        repeat (6) rstep(0, 1, 1, 1, 2'b00);

        // Error then OKAY response
        rstep(1, 1, 1, 0, 2'b00);
        rstep(1, 1, 1, 0, 2'b00);
        rstep(0, 1, 1, 1, 2'b10);
        rstep(0, 1, 1, 1, 2'b00);
        repeat (3) rstep(0, 1, 1, 0, 2'b00);

        // Reset with writes in flight, then a fresh write
        repeat (3) rstep(1, 0, 0, 0, 2'b00);
        repeat (2) rstep(0, 1, 1, 0, 2'b00);
        rstep(0, 1, 1, 1, 2'b01);
        do_reset(1);
        rstep(0, 1, 1, 1, 2'b00);
        rstep(1, 1, 1, 1, 2'b00);
        repeat (4) rstep(0, 1, 1, 1, 2'b11);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset(1);
            rstep($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                  2'($urandom()));
        end
        repeat (12) rstep(0, 1, 1, 1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi4_lite_write_master_q.md
# axi4_lite_write_master_q

Parametrised, queued AXI4-lite write master. It replaces the single-shot write master with a request FIFO of `QDEPTH` entries, byte strobes, and per-write completion/response reporting. AW and W channels issue independently, so several writes are in flight at once. It sits between the core's store path and the AXI4-lite write slave/interconnect.

## Interface
- `ADDR_W`, 64, address width.
- `DATA_W`, 64, data width; multiple of 8.
- `QDEPTH`, 4, request queue depth; power of 2, ≥2.

- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  reset; synchronous, active-low.
- `REQ_VALID`  in  1  write request offered.
- `REQ_READY`  out  1  queue can accept.
- `REQ_ADDR`  in  ADDR_W  byte address.
- `REQ_DATA`  in  DATA_W  write data.
- `REQ_STRB`  in  DATA_W/8  byte enables.
- `AW_ADDR`  out  ADDR_W  write address.
- `AW_PROT`  out  3  constant 3'b000.
- `AW_VALID` / `AW_READY`  out / in  1  AW handshake.
- `W_DATA`  out  DATA_W  write data.
- `W_STRB`  out  DATA_W/8  write strobes.
- `W_VALID` / `W_READY`  out / in  1  W handshake.
- `B_RESP`  in  2  write response.
- `B_VALID` / `B_READY`  in / out  1  B handshake.
- `DONE`  out  1  one-cycle pulse per retired write.
- `DONE_RESP`  out  2  `B_RESP` of the retired write, valid with `DONE`.
- `PENDING`  out  clog2(QDEPTH)+1  entries held (queued plus in flight).

## Operation
- Storage: `QDEPTH` × {addr, data, strb} array. Four pointers, each clog2(QDEPTH)+1 bits with a wrap bit: `wr_ptr`, `aw_ptr`, `w_ptr`, `b_ptr`.
- Enqueue: `REQ_VALID && REQ_READY` writes the entry at `wr_ptr` and increments `wr_ptr`.
- `PENDING = wr_ptr - b_ptr`. `REQ_READY = (PENDING != QDEPTH) && RST`.
- AW: `AW_VALID = (aw_ptr != wr_ptr)`. `AW_ADDR = addr[aw_ptr]`. `aw_ptr` increments on `AW_VALID && AW_READY`.
- W: `W_VALID = (w_ptr != wr_ptr)`. `W_DATA` / `W_STRB` come from entry `w_ptr`. `w_ptr` increments on `W_VALID && W_READY`.
- AW and W are fully decoupled. Either may run ahead of the other by up to `PENDING` entries.
- B: `B_READY = (aw_ptr != b_ptr) && (w_ptr != b_ptr)`, i.e. the oldest entry has had both AW and W accepted. On `B_VALID && B_READY`: `b_ptr` increments, `DONE` is registered to 1, and `DONE_RESP` is registered from `B_RESP`.
- Responses retire strictly in order (single-ID AXI4-lite).
- An entry is not overwritten until it retires, so AW/W payloads stay stable while VALID is high.
- VALID never depends on READY. Once asserted, VALID holds until its handshake.
- Any non-OKAY response (SLVERR/DECERR) is reported on `DONE_RESP` only. There is no retry and no stall.

## Timing
- Reset (`RST` low at a rising edge): all pointers 0. `AW_VALID`, `W_VALID`, `B_READY`, `DONE`, `DONE_RESP`, `PENDING` = 0.
- `REQ_READY` is 0 while `RST` is low and 1 in the first cycle after release.
- Request accepted at edge N → `AW_VALID` and `W_VALID` high from cycle N+1. With `AW_READY` = `W_READY` = 1, both handshakes occur at edge N+1.
- B handshake at edge M → `DONE` high during cycle M+1 only.
- Throughput: one request per cycle while `PENDING < QDEPTH`.
- Full queue: a retire and an enqueue attempt in the same cycle do not bypass. `REQ_READY` stays 0 for that cycle and rises the next cycle.
- Simultaneous enqueue and retire when not full: `PENDING` is unchanged.
- Pointer wrap: the wrap bit distinguishes full from empty. Indices use only the low clog2(QDEPTH) bits.
- Reset mid-operation: the queue and all in-flight transactions are discarded with no `DONE`. The downstream slave must be reset in the same cycle.

## Configuration
- `AXI_WR_STRB_EN` defined: `W_STRB` carries the queued `REQ_STRB`.
- Not defined: the strb array is not instantiated, `REQ_STRB` is ignored, and `W_STRB` is constant all-ones (full-width writes only).

## Test plan
- Single write: REQ addr 0x8000_0010, data 0x1122334455667788, strb 0xFF, slave always ready, B OKAY after 1 cycle → exactly one AW and one W handshake with matching values; `DONE`=1 for one cycle, `DONE_RESP`=0; `PENDING` goes 0→1→0.
- Fill queue: QDEPTH=4, hold `AW_READY`=0 and `W_READY`=0, offer 5 requests → 4 accepted, `REQ_READY`=0, `PENDING`=4. Then release both READYs and ack all B → 4 in-order `DONE`, then the 5th request is accepted.
- Decoupled channels: `W_READY`=1, `AW_READY`=0 for 10 cycles, 3 requests → 3 W handshakes and no B_READY. Then `AW_READY`=1 → `B_READY` rises after the first AW handshake; responses retire in order.
- Error response: 2 writes, B_RESP = 2'b10 then 2'b00 → `DONE_RESP` = 2 then 0; no retry or extra handshake.
- Reset mid-flight: 3 writes accepted, 1 retired, drive `RST`=0 for one edge → all VALID/READY outputs 0, `PENDING`=0, no `DONE`; a new write after release completes normally.
- Strobes: REQ_STRB=0x0F. With `AXI_WR_STRB_EN` → `W_STRB`=0x0F. Without it → `W_STRB`=0xFF.
